// File: rtl/lane_signal_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lane_signal_sequencer
// Description : Drives per-lane red/yellow/green lamps from a go vector,
//               inserting timed yellow and all-red phases on dropped lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_signal_sequencer #(
    parameter int NUM_LANES    = 8,
    parameter int YELLOW_TIME  = 3,
    parameter int ALL_RED_TIME = 2,
    parameter int CNT_W        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_LANES-1:0] grantIn,
    output logic [NUM_LANES-1:0] red,
    output logic [NUM_LANES-1:0] yellow,
    output logic [NUM_LANES-1:0] green,
    output logic                 busy,
    output logic                 changeDone
);

    localparam logic [1:0] c_HOLD   = 2'd0;
    localparam logic [1:0] c_YELLOW = 2'd1;
    localparam logic [1:0] c_ALLRED = 2'd2;

    localparam logic [CNT_W-1:0] c_YELLOW_LOAD = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] c_ALLRED_LOAD =
        (ALL_RED_TIME > 0) ? CNT_W'(ALL_RED_TIME - 1) : '0;

    logic [1:0]           r_state;
    logic [NUM_LANES-1:0] r_applied;
    logic [NUM_LANES-1:0] r_target;
    logic [CNT_W-1:0]     r_cnt;

    logic [1:0]           w_nextState;
    logic [NUM_LANES-1:0] w_nextApplied;
    logic [NUM_LANES-1:0] w_nextTarget;
    logic [CNT_W-1:0]     w_nextCnt;
    logic                 w_nextDone;
    logic [NUM_LANES-1:0] w_drop;
    logic [NUM_LANES-1:0] w_nextRed;
    logic [NUM_LANES-1:0] w_nextYellow;
    logic [NUM_LANES-1:0] w_nextGreen;

    assign w_drop = r_applied & ~grantIn;

    always_comb begin
        w_nextState   = r_state;
        w_nextApplied = r_applied;
        w_nextTarget  = r_target;
        w_nextCnt     = r_cnt;
        w_nextDone    = 1'b0;
        case (r_state)
            c_HOLD: begin
                if (grantIn != r_applied) begin
                    // Pure additions need no clearance and apply immediately
                    if (w_drop == '0) begin
                        w_nextApplied = grantIn;
                        w_nextDone    = 1'b1;
                    end else begin
                        w_nextTarget = grantIn;
                        w_nextCnt    = c_YELLOW_LOAD;
                        w_nextState  = c_YELLOW;
                    end
                end
            end
            c_YELLOW: begin
                if (r_cnt != '0) begin
                    w_nextCnt = r_cnt - CNT_W'(1);
                end else if (ALL_RED_TIME > 0) begin
                    w_nextCnt   = c_ALLRED_LOAD;
                    w_nextState = c_ALLRED;
                end else begin
                    w_nextApplied = r_target;
                    w_nextDone    = 1'b1;
                    w_nextState   = c_HOLD;
                end
            end
            c_ALLRED: begin
                if (r_cnt != '0) begin
                    w_nextCnt = r_cnt - CNT_W'(1);
                end else begin
                    w_nextApplied = r_target;
                    w_nextDone    = 1'b1;
                    w_nextState   = c_HOLD;
                end
            end
            default: begin
                w_nextState = c_HOLD;
            end
        endcase
    end

    // Lamps are decoded from next-cycle state so the registered outputs
    // line up with the state/applied/target they describe.
    always_comb begin
        w_nextRed    = '1;
        w_nextYellow = '0;
        w_nextGreen  = '0;
        case (w_nextState)
            c_HOLD: begin
                w_nextGreen = w_nextApplied;
                w_nextRed   = ~w_nextApplied;
            end
            c_YELLOW: begin
                w_nextYellow = w_nextApplied & ~w_nextTarget;
                w_nextGreen  = w_nextApplied & w_nextTarget;
                w_nextRed    = ~w_nextApplied;
            end
            c_ALLRED: begin
                w_nextGreen = w_nextApplied & w_nextTarget;
                w_nextRed   = ~(w_nextApplied & w_nextTarget);
            end
            default: begin
                w_nextRed = '1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_HOLD;
            r_applied  <= '0;
            r_target   <= '0;
            r_cnt      <= '0;
            red        <= '1;
            yellow     <= '0;
            green      <= '0;
            busy       <= 1'b0;
            changeDone <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_applied  <= w_nextApplied;
            r_target   <= w_nextTarget;
            r_cnt      <= w_nextCnt;
            red        <= w_nextRed;
            yellow     <= w_nextYellow;
            green      <= w_nextGreen;
            busy       <= (w_nextState != c_HOLD);
            changeDone <= w_nextDone;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lane_signal_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lane_signal_sequencer
// Description : Scoreboard bench for lane_signal_sequencer, default build and
//               a zero all-red build, driven by hand-computed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lane_signal_sequencer;

    typedef struct {
        int         cyc;
        logic [7:0] r;
        logic [7:0] y;
        logic [7:0] g;
        logic       b;
        logic       d;
        string      nm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] grantA = 8'h00;
    logic [7:0] grantB = 8'h00;
    logic [7:0] redA, yellowA, greenA, redB, yellowB, greenB;
    logic       busyA, doneA, busyB, doneB;

    int   cycle   = 0;
    int   nChecks = 0;
    int   nFails  = 0;
    exp_t qA[$];
    exp_t qB[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    lane_signal_sequencer #(.NUM_LANES(8), .YELLOW_TIME(3), .ALL_RED_TIME(2), .CNT_W(4)) dutA (
        .clk(clk), .rst(rst), .grantIn(grantA),
        .red(redA), .yellow(yellowA), .green(greenA),
        .busy(busyA), .changeDone(doneA)
    );

    lane_signal_sequencer #(.NUM_LANES(8), .YELLOW_TIME(3), .ALL_RED_TIME(0), .CNT_W(4)) dutB (
        .clk(clk), .rst(rst), .grantIn(grantB),
        .red(redB), .yellow(yellowB), .green(greenB),
        .busy(busyB), .changeDone(doneB)
    );

    task automatic compare(input exp_t e, input string tag, input logic [7:0] r, input logic [7:0] y,
                           input logic [7:0] g, input logic b, input logic d);
        nChecks++;
        if (r !== e.r || y !== e.y || g !== e.g || b !== e.b || d !== e.d) begin
            nFails++;
            $display("FAIL %s.%s cyc=%0d got r=%h y=%h g=%h busy=%b done=%b want r=%h y=%h g=%h busy=%b done=%b",
                     tag, e.nm, e.cyc, r, y, g, b, d, e.r, e.y, e.g, e.b, e.d);
        end
        // Every lane shows exactly one lamp
        nChecks++;
        if ((r | y | g) !== 8'hFF || ((r & y) | (r & g) | (y & g)) !== 8'h00) begin
            nFails++;
            $display("FAIL %s.%s.onehot cyc=%0d got r=%h y=%h g=%h want one lamp per lane", tag, e.nm, e.cyc, r, y, g);
        end
    endtask

    // Monitor: pops expectations due this cycle and checks them
    always @(negedge clk) begin
        while (qA.size() > 0 && qA[0].cyc == cycle) begin
            exp_t e;
            e = qA.pop_front();
            compare(e, "A", redA, yellowA, greenA, busyA, doneA);
        end
        while (qB.size() > 0 && qB[0].cyc == cycle) begin
            exp_t e;
            e = qB.pop_front();
            compare(e, "B", redB, yellowB, greenB, busyB, doneB);
        end
    end

    // One clock of stimulus; expectation is for the outputs after the next edge
    task automatic step(input bit sel, input logic rv, input logic [7:0] gnt,
                        input logic [7:0] er, input logic [7:0] ey, input logic [7:0] eg,
                        input logic eb, input logic ed, input string nm);
        exp_t e;
        @(negedge clk);
        rst = rv;
        if (sel) grantB = gnt; else grantA = gnt;
        e.cyc = cycle + 1;
        e.r = er; e.y = ey; e.g = eg; e.b = eb; e.d = ed; e.nm = nm;
        if (sel) qB.push_back(e); else qA.push_back(e);
    endtask

    initial begin
        // Default build: reset and idle
        step(0, 1, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 0, "reset0");
        step(0, 1, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 0, "reset1");
        step(0, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 0, "idle0");
        step(0, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 0, "idle1");
        // Additions-only change
        step(0, 0, 8'h11, 8'hEE, 8'h00, 8'h11, 0, 1, "add11");
        step(0, 0, 8'h11, 8'hEE, 8'h00, 8'h11, 0, 0, "hold11");
        // 11 -> 22 full sequence
        step(0, 0, 8'h22, 8'hEE, 8'h11, 8'h00, 1, 0, "y1");
        step(0, 0, 8'h22, 8'hEE, 8'h11, 8'h00, 1, 0, "y2");
        step(0, 0, 8'h22, 8'hEE, 8'h11, 8'h00, 1, 0, "y3");
        step(0, 0, 8'h22, 8'hFF, 8'h00, 8'h00, 1, 0, "ar1");
        step(0, 0, 8'h22, 8'hFF, 8'h00, 8'h00, 1, 0, "ar2");
        step(0, 0, 8'h22, 8'hDD, 8'h00, 8'h22, 0, 1, "done22");
        step(0, 0, 8'h22, 8'hDD, 8'h00, 8'h22, 0, 0, "hold22");
        // 22 -> 00
        step(0, 0, 8'h00, 8'hDD, 8'h22, 8'h00, 1, 0, "y0a");
        step(0, 0, 8'h00, 8'hDD, 8'h22, 8'h00, 1, 0, "y0b");
        step(0, 0, 8'h00, 8'hDD, 8'h22, 8'h00, 1, 0, "y0c");
        step(0, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 1, 0, "ar0a");
        step(0, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 1, 0, "ar0b");
        step(0, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 1, "done00");
        // Back-to-back additions, then 13 -> 03 keeps lanes 0/1 green
        step(0, 0, 8'h03, 8'hFC, 8'h00, 8'h03, 0, 1, "add03");
        step(0, 0, 8'h13, 8'hEC, 8'h00, 8'h13, 0, 1, "add13");
        step(0, 0, 8'h03, 8'hEC, 8'h10, 8'h03, 1, 0, "keep_y1");
        step(0, 0, 8'h03, 8'hEC, 8'h10, 8'h03, 1, 0, "keep_y2");
        step(0, 0, 8'h03, 8'hEC, 8'h10, 8'h03, 1, 0, "keep_y3");
        step(0, 0, 8'h03, 8'hFC, 8'h00, 8'h03, 1, 0, "keep_ar1");
        step(0, 0, 8'h03, 8'hFC, 8'h00, 8'h03, 1, 0, "keep_ar2");
        step(0, 0, 8'h03, 8'hFC, 8'h00, 8'h03, 0, 1, "done03");
        // 03 -> 11: lane 0 kept, lane 1 dropped
        step(0, 0, 8'h11, 8'hFC, 8'h02, 8'h01, 1, 0, "m_y1");
        step(0, 0, 8'h11, 8'hFC, 8'h02, 8'h01, 1, 0, "m_y2");
        step(0, 0, 8'h11, 8'hFC, 8'h02, 8'h01, 1, 0, "m_y3");
        step(0, 0, 8'h11, 8'hFE, 8'h00, 8'h01, 1, 0, "m_ar1");
        step(0, 0, 8'h11, 8'hFE, 8'h00, 8'h01, 1, 0, "m_ar2");
        step(0, 0, 8'h11, 8'hEE, 8'h00, 8'h11, 0, 1, "done11");
        // Grant changes to 44 during yellow: finish 22, then run to 44
        step(0, 0, 8'h22, 8'hEE, 8'h11, 8'h00, 1, 0, "t_y1");
        step(0, 0, 8'h44, 8'hEE, 8'h11, 8'h00, 1, 0, "t_y2");
        step(0, 0, 8'h44, 8'hEE, 8'h11, 8'h00, 1, 0, "t_y3");
        step(0, 0, 8'h44, 8'hFF, 8'h00, 8'h00, 1, 0, "t_ar1");
        step(0, 0, 8'h44, 8'hFF, 8'h00, 8'h00, 1, 0, "t_ar2");
        step(0, 0, 8'h44, 8'hDD, 8'h00, 8'h22, 0, 1, "t_done22");
        step(0, 0, 8'h44, 8'hDD, 8'h22, 8'h00, 1, 0, "t2_y1");
        step(0, 0, 8'h44, 8'hDD, 8'h22, 8'h00, 1, 0, "t2_y2");
        step(0, 0, 8'h44, 8'hDD, 8'h22, 8'h00, 1, 0, "t2_y3");
        step(0, 0, 8'h44, 8'hFF, 8'h00, 8'h00, 1, 0, "t2_ar1");
        step(0, 0, 8'h44, 8'hFF, 8'h00, 8'h00, 1, 0, "t2_ar2");
        step(0, 0, 8'h44, 8'hBB, 8'h00, 8'h44, 0, 1, "t2_done44");
        // Reset in the middle of ALLRED
        step(0, 0, 8'h00, 8'hBB, 8'h44, 8'h00, 1, 0, "r_y1");
        step(0, 0, 8'h00, 8'hBB, 8'h44, 8'h00, 1, 0, "r_y2");
        step(0, 0, 8'h00, 8'hBB, 8'h44, 8'h00, 1, 0, "r_y3");
        step(0, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 1, 0, "r_ar1");
        step(0, 1, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 0, "r_reset");
        step(0, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 0, "r_idle");
        // Zero all-red build: yellow then direct change
        step(1, 0, 8'h11, 8'hEE, 8'h00, 8'h11, 0, 1, "b_add11");
        step(1, 0, 8'h22, 8'hEE, 8'h11, 8'h00, 1, 0, "b_y1");
        step(1, 0, 8'h22, 8'hEE, 8'h11, 8'h00, 1, 0, "b_y2");
        step(1, 0, 8'h22, 8'hEE, 8'h11, 8'h00, 1, 0, "b_y3");
        step(1, 0, 8'h22, 8'hDD, 8'h00, 8'h22, 0, 1, "b_done22");
        step(1, 0, 8'h22, 8'hDD, 8'h00, 8'h22, 0, 0, "b_hold22");
        repeat (3) @(negedge clk);
        nChecks++;
        if (qA.size() != 0 || qB.size() != 0) begin
            nFails++;
            $display("FAIL drain got %0d/%0d pending want 0/0", qA.size(), qB.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lane_signal_sequencer.md
Name: lane_signal_sequencer

Overview:
- Sits directly downstream of the traffic-mode light-output mux; consumes the 8-bit per-lane "go" vector and drives the physical red/yellow/green lamps for each lane.
- Any lane losing its go bit passes through a timed yellow phase, then a timed all-red clearance, before newly granted lanes turn green.
- Lanes that keep their go bit across a change stay green throughout.
- Runs on the 1-second system clock, so all timing constants are in seconds.

Parameters:
- NUM_LANES, 8, number of lanes, which is the width of every lane vector.
- YELLOW_TIME, 3, cycles a dropped lane shows yellow; legal range 1..15.
- ALL_RED_TIME, 2, cycles of clearance after yellow; legal range 0..15, where 0 skips the clearance phase.
- CNT_W, 4, phase counter width; must hold max(YELLOW_TIME, ALL_RED_TIME).

Ports:
- clk, input, 1, system clock, 1 Hz.
- rst, input, 1, synchronous active-high reset.
- grantIn, input, NUM_LANES, requested go vector from the light-output mux; bit i = 1 means lane i may go.
- red, output, NUM_LANES, red lamp per lane.
- yellow, output, NUM_LANES, yellow lamp per lane.
- green, output, NUM_LANES, green lamp per lane.
- busy, output, 1, high while a change is in progress (YELLOW or ALLRED state).
- changeDone, output, 1, one-cycle pulse in the cycle a new applied vector takes effect.

Behaviour:
- Internal registers:
  - applied[NUM_LANES]: lanes currently green.
  - target[NUM_LANES]: latched destination vector.
  - cnt[CNT_W]: phase counter.
  - state, one of HOLD, YELLOW, ALLRED.
- All outputs are registered; they reflect state/applied/target of the current cycle.
- Reset (rst=1 at a clock edge, overrides everything, including mid-transition):
  - state=HOLD, applied=0, target=0, cnt=0.
  - red=all 1s, yellow=0, green=0, busy=0, changeDone=0.
- HOLD:
  - green=applied, red=~applied, yellow=0.
  - Each cycle compute drop = applied & ~grantIn.
  - grantIn==applied: stay in HOLD.
  - grantIn!=applied and drop==0 (additions only): next cycle applied=grantIn and changeDone=1; stay in HOLD. Latency is 1 cycle.
  - drop!=0: latch target=grantIn, cnt=YELLOW_TIME-1, go to YELLOW.
- YELLOW:
  - yellow = applied & ~target.
  - green = applied & target.
  - red = ~applied.
  - cnt!=0: decrement cnt.
  - cnt==0 and ALL_RED_TIME>0: cnt=ALL_RED_TIME-1, go to ALLRED.
  - cnt==0 and ALL_RED_TIME==0: applied=target, changeDone=1, go to HOLD.
  - Yellow is therefore visible for exactly YELLOW_TIME cycles.
- ALLRED:
  - green = applied & target.
  - red = ~(applied & target).
  - yellow=0.
  - Decrement cnt; at cnt==0: applied=target, changeDone=1, go to HOLD.
  - Red clearance is visible for exactly ALL_RED_TIME cycles.
- grantIn is ignored while busy=1. After returning to HOLD it is compared again on the next cycle, so an intervening change starts a fresh sequence from the new applied vector.
- Invariant, every cycle, every lane: exactly one of red/yellow/green is 1.
- Invariant: a lane goes from green to red only through yellow.
- Invariant: a lane goes from red to green only at a changeDone cycle.
- busy = (state!=HOLD).
- changeDone is never high in two consecutive cycles, except for back-to-back additions-only changes in HOLD.

Test Plan:
- Reset, then grantIn=8'h00 held -> red=8'hFF, yellow=0, green=0, busy=0, changeDone never pulses.
- From reset, grantIn=8'h11 -> one cycle later green=8'h11, red=8'hEE, changeDone=1 for one cycle, busy stays 0.
- applied=8'h11, grantIn=8'h22, default params -> 3 cycles with yellow=8'h11, then 2 cycles with red=8'hFF, then green=8'h22 with changeDone=1; busy high for 5 cycles.
- applied=8'h13, grantIn=8'h03 -> lanes 0 and 1 stay green throughout; lane 4 is yellow 3 cycles then red; total 5 busy cycles; final green=8'h03.
- During YELLOW, toggle grantIn to 8'h44 -> the current sequence completes to target 8'h22, then a new 5-cycle sequence runs to 8'h44.
- Assert rst mid-ALLRED -> next cycle red=8'hFF, busy=0, applied=0; with ALL_RED_TIME=0 build, a drop gives yellow 3 cycles then direct changeDone.
